// File: rtl/denoise_scheduler_pkg.sv
// rtl/denoise_scheduler_pkg.sv - shared pixel widths and FSM encoding for the denoise scheduler
package denoise_pkg;

    localparam int PIX_W   = 8;
    localparam int WIN_PIX = 70;
    localparam int BLK_PIX = 9;
    localparam int OUT_PIX = 36;

    localparam int WIN_W = WIN_PIX * PIX_W;
    localparam int BLK_W = BLK_PIX * PIX_W;
    localparam int OUT_W = OUT_PIX * PIX_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/denoise_scheduler_fifo.sv
// rtl/denoise_scheduler_fifo.sv - synchronous result FIFO with occupancy count
module sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/denoise_scheduler.sv
// rtl/denoise_scheduler.sv - frame sequencer feeding the denoise core and packing 6x6 result tiles
// Optional stall counter output enabled by DENOISE_SCHED_STALL_CNT_EN.
module denoise_scheduler
    import denoise_pkg::*;
#(
    parameter int DN_LAT     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TW         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TW-1:0]     cfg_tiles_x,
    input  logic [TW-1:0]     cfg_tiles_y,
    output logic              busy,
    output logic              frame_done,
    input  logic              win_valid,
    output logic              win_ready,
    input  logic [WIN_W-1:0]  win_data,
    output logic [WIN_W-1:0]  dn_pix,
    input  logic [BLK_W-1:0]  dn_blk0,
    input  logic [BLK_W-1:0]  dn_blk1,
    input  logic [BLK_W-1:0]  dn_blk2,
    input  logic [BLK_W-1:0]  dn_blk3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [TW-1:0]     out_x,
    output logic [TW-1:0]     out_y,
    output logic              out_last
`ifdef DENOISE_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int STAGES = DN_LAT + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FIFO_W = OUT_W + 2 * TW + 1;

    sched_state_t     state_q;
    logic [TW-1:0]    tiles_x_q;
    logic [TW-1:0]    tiles_y_q;
    logic [TW-1:0]    x_q;
    logic [TW-1:0]    y_q;
    logic [CNT_W-1:0] inflight_q;
    logic [WIN_W-1:0] dn_pix_q;

    logic [STAGES-1:0] tag_v_q;
    logic [TW-1:0]     tag_x_q [STAGES];
    logic [TW-1:0]     tag_y_q [STAGES];
    logic              tag_l_q [STAGES];

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [FIFO_W-1:0] fifo_wdata;
    logic [FIFO_W-1:0] fifo_rdata;
    logic [OUT_W-1:0]  rd_data;
    logic [TW-1:0]     rd_x;
    logic [TW-1:0]     rd_y;
    logic              rd_last;

    logic [CNT_W:0] credit_sum;
    logic           credit_ok;
    logic           issue;
    logic           push;
    logic           pop;
    logic           x_end;
    logic           last_pos;

    // Core cannot stall, so every issued window must already own a FIFO slot.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign credit_ok  = credit_sum < (CNT_W+1)'(FIFO_DEPTH);
    assign win_ready  = (state_q == RUN) && credit_ok;
    assign issue      = win_valid && win_ready;
    assign push       = tag_v_q[STAGES-1];
    assign pop        = out_valid && out_ready;

    assign x_end    = (x_q == tiles_x_q - TW'(1));
    assign last_pos = x_end && (y_q == tiles_y_q - TW'(1));

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tiles_x_q <= '0;
            tiles_y_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tiles_x_q <= cfg_tiles_x;
                        tiles_y_q <= cfg_tiles_y;
                        x_q       <= '0;
                        y_q       <= '0;
                        if (cfg_tiles_x == '0 || cfg_tiles_y == '0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (last_pos) begin
                            state_q <= DRAIN;
                        end else if (x_end) begin
                            x_q <= '0;
                            y_q <= y_q + TW'(1);
                        end else begin
                            x_q <= x_q + TW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (inflight_q == '0 && fifo_empty) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else if (issue && !push) begin
            inflight_q <= inflight_q + CNT_W'(1);
        end else if (!issue && push) begin
            inflight_q <= inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_pix_q <= '0;
        end else if (issue) begin
            dn_pix_q <= win_data;
        end
    end

    assign dn_pix = dn_pix_q;

    // Tag pipeline mirrors the core latency plus the dn_pix register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q <= '0;
        end else begin
            tag_v_q <= {tag_v_q[STAGES-2:0], issue};
        end
    end

    always_ff @(posedge clk) begin
        tag_x_q[0] <= x_q;
        tag_y_q[0] <= y_q;
        tag_l_q[0] <= last_pos;
        for (int i = 1; i < STAGES; i++) begin
            tag_x_q[i] <= tag_x_q[i-1];
            tag_y_q[i] <= tag_y_q[i-1];
            tag_l_q[i] <= tag_l_q[i-1];
        end
    end

    assign fifo_wdata = {dn_blk3, dn_blk2, dn_blk1, dn_blk0,
                         tag_x_q[STAGES-1], tag_y_q[STAGES-1], tag_l_q[STAGES-1]};

    sched_fifo #(
        .W     (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_data_i (fifo_wdata),
        .pop_i       (pop),
        .pop_data_o  (fifo_rdata),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign {rd_data, rd_x, rd_y, rd_last} = fifo_rdata;

    // Unoccupied FIFO slots hold stale data; present zeros instead.
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? rd_data : '0;
    assign out_x     = out_valid ? rd_x    : '0;
    assign out_y     = out_valid ? rd_y    : '0;
    assign out_last  = out_valid && rd_last;

`ifdef DENOISE_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state_q == IDLE && start) begin
            stall_cnt_q <= '0;
        end else if (state_q == RUN && win_valid && !win_ready && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
